// File: rtl/mmu_ctx_ctrl.sv
// mmu_ctx_ctrl: sequences MMU selector, base and mode writes for a
// context switch, tracks programmed slots and forces kernel mode on traps.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start             request strobe (taken only when idle)
//   proc_id, base     target slot and its instruction-memory base
//   load, enter_user  write base / switch to user at end
//   trap              exception or syscall, forces kernel mode
//   we_sel, sel       MMU selector strobe and value
//   we_addr, offset   MMU base strobe and value
//   userMode          MMU enter-user pulse
//   kernelMode        MMU enter-kernel pulse
//   busy, done, err   sequence status
//   mode              mirrored MMU mode (0 kernel, 1 user)

module mmu_ctx_ctrl #(
  parameter int NUM_SLOTS = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] proc_id,
  input  logic [31:0] base,
  input  logic        load,
  input  logic        enter_user,
  input  logic        trap,
  output logic        we_sel,
  output logic [31:0] sel,
  output logic        we_addr,
  output logic [31:0] offset,
  output logic        userMode,
  output logic        kernelMode,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        mode
);

  localparam int IW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEL,
    S_BASE,
    S_MODE,
    S_DONE,
    S_ERR
  } state_t;

  state_t               r_state;
  logic [NUM_SLOTS-1:0] r_valid;
  logic                 r_cancel;
  logic [31:0]          r_id;
  logic [31:0]          r_base;
  logic                 r_load;
  logic                 r_user;

  logic                 r_we_sel;
  logic [31:0]          r_sel;
  logic                 r_we_addr;
  logic [31:0]          r_offset;
  logic                 r_upulse;
  logic                 r_kpulse;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_err;
  logic                 r_mode;

  logic w_in_range;
  logic w_slot_vld;
  logic w_cancel_now;
  logic w_ok_user;

  assign w_in_range = proc_id < 32'(NUM_SLOTS);
  assign w_slot_vld = w_in_range && r_valid[proc_id[IW-1:0]];

  // A trap seen this very edge in SEL/BASE must already veto the
  // user switch decided on the same edge.
  assign w_cancel_now = trap &&
    (r_state == S_SEL || r_state == S_BASE);
  assign w_ok_user = r_user && !r_cancel && !w_cancel_now;

  // Outputs are registered alongside the state they belong to, so
  // each strobe is high for exactly the cycle spent in its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_valid   <= '0;
      r_cancel  <= 1'b0;
      r_id      <= '0;
      r_base    <= '0;
      r_load    <= 1'b0;
      r_user    <= 1'b0;
      r_we_sel  <= 1'b0;
      r_sel     <= '0;
      r_we_addr <= 1'b0;
      r_offset  <= '0;
      r_upulse  <= 1'b0;
      r_kpulse  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_mode    <= 1'b0;
    end else begin
      r_we_sel  <= 1'b0;
      r_we_addr <= 1'b0;
      r_upulse  <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_kpulse  <= trap;
      if (w_cancel_now) r_cancel <= 1'b1;

      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_id     <= proc_id;
            r_base   <= base;
            r_load   <= load;
            r_user   <= enter_user;
            r_cancel <= 1'b0;
            r_busy   <= 1'b1;
            if (!w_in_range || (!load && !w_slot_vld)) begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end else begin
              r_state  <= S_SEL;
              r_we_sel <= 1'b1;
              r_sel    <= proc_id;
            end
          end
        end
        S_SEL: begin
          if (r_load) begin
            r_state   <= S_BASE;
            r_we_addr <= 1'b1;
            r_offset  <= r_base;
            r_valid[r_id[IW-1:0]] <= 1'b1;
          end else begin
            r_state <= S_MODE;
            if (w_ok_user) begin
              r_upulse <= 1'b1;
              r_mode   <= 1'b1;
            end
          end
        end
        S_BASE: begin
          r_state <= S_MODE;
          if (w_ok_user) begin
            r_upulse <= 1'b1;
            r_mode   <= 1'b1;
          end
        end
        S_MODE: begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
        S_DONE, S_ERR: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase

      // Trap wins over any user switch on the same edge.
      if (trap) r_mode <= 1'b0;
    end
  end

  assign we_sel     = r_we_sel;
  assign sel        = r_sel;
  assign we_addr    = r_we_addr;
  assign offset     = r_offset;
  assign userMode   = r_upulse;
  assign kernelMode = r_kpulse;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign mode       = r_mode;

endmodule

// File: tb/tb_mmu_ctx_ctrl.sv
// tb_mmu_ctx_ctrl: directed bench for the context-switch sequencer.
// Status bits: we_sel we_addr userMode kernelMode busy done err mode.

module tb_mmu_ctx_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] proc_id = '0;
  logic [31:0] base = '0;
  logic        load = 1'b0;
  logic        enter_user = 1'b0;
  logic        trap = 1'b0;

  logic        we_sel;
  logic [31:0] sel;
  logic        we_addr;
  logic [31:0] offset;
  logic        userMode;
  logic        kernelMode;
  logic        busy;
  logic        done;
  logic        err;
  logic        mode;

  logic [7:0]  obs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mmu_ctx_ctrl #(.NUM_SLOTS(11)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .proc_id    (proc_id),
    .base       (base),
    .load       (load),
    .enter_user (enter_user),
    .trap       (trap),
    .we_sel     (we_sel),
    .sel        (sel),
    .we_addr    (we_addr),
    .offset     (offset),
    .userMode   (userMode),
    .kernelMode (kernelMode),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .mode       (mode)
  );

  assign obs = {we_sel, we_addr, userMode, kernelMode,
                busy, done, err, mode};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one request; the inputs are scrambled right after the
  // accepting edge so only latched values can produce correct output.
  task automatic issue(input logic [31:0] id, input logic [31:0] b,
                       input logic ld, input logic u);
    proc_id    = id;
    base       = b;
    load       = ld;
    enter_user = u;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    proc_id    = id + 32'd1;
    base       = ~b;
    load       = ~ld;
    enter_user = ~u;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL reset_obs: got %b want %b", obs, 8'h00);
    end
    checks++;
    if (sel !== 32'h0 || offset !== 32'h0) begin
      errors++;
      $display("FAIL reset_regs: got sel=%h off=%h want 0 0",
               sel, offset);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL reset_release: got %b want %b", obs, 8'h00);
    end
  endtask

  task automatic test_load_user();
    logic [7:0] e [5] = '{8'h88, 8'h48, 8'h29, 8'h0D, 8'h01};
    issue(32'd3, 32'h400, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      checks++;
      if (obs !== e[k]) begin
        errors++;
        $display("FAIL load_user c%0d: got %b want %b", k, obs, e[k]);
      end
      if (k == 0) begin
        checks++;
        if (sel !== 32'd3) begin
          errors++;
          $display("FAIL load_user sel: got %0d want 3", sel);
        end
      end
      if (k == 1) begin
        checks++;
        if (offset !== 32'h400) begin
          errors++;
          $display("FAIL load_user off: got %h want 400", offset);
        end
      end
    end
  endtask

  task automatic test_reuse();
    logic [7:0] e [4] = '{8'h89, 8'h29, 8'h0D, 8'h01};
    logic [7:0] f [2] = '{8'h0B, 8'h01};
    issue(32'd3, 32'hDEAD, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      checks++;
      if (obs !== e[k]) begin
        errors++;
        $display("FAIL reuse c%0d: got %b want %b", k, obs, e[k]);
      end
    end
    checks++;
    if (offset !== 32'h400 || sel !== 32'd3) begin
      errors++;
      $display("FAIL reuse hold: got sel=%0d off=%h want 3 400",
               sel, offset);
    end
    issue(32'd5, 32'h500, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      if (k > 0) tick();
      checks++;
      if (obs !== f[k]) begin
        errors++;
        $display("FAIL unloaded c%0d: got %b want %b", k, obs, f[k]);
      end
    end
  endtask

  task automatic test_bad_id();
    logic [7:0] e [2] = '{8'h0B, 8'h01};
    issue(32'd11, 32'h800, 1'b1, 1'b1);
    for (int k = 0; k < 2; k++) begin
      if (k > 0) tick();
      checks++;
      if (obs !== e[k]) begin
        errors++;
        $display("FAIL bad_id c%0d: got %b want %b", k, obs, e[k]);
      end
    end
    checks++;
    if (sel !== 32'd3 || offset !== 32'h400) begin
      errors++;
      $display("FAIL bad_id hold: got sel=%0d off=%h want 3 400",
               sel, offset);
    end
  endtask

  task automatic test_trap_cancel();
    logic [7:0] e [5] = '{8'h89, 8'h58, 8'h08, 8'h0C, 8'h00};
    issue(32'd4, 32'h600, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin
        trap = 1'b1;
        tick();
        trap = 1'b0;
      end else if (k > 0) begin
        tick();
      end
      checks++;
      if (obs !== e[k]) begin
        errors++;
        $display("FAIL trap_cancel c%0d: got %b want %b",
                 k, obs, e[k]);
      end
      if (k == 1) begin
        checks++;
        if (offset !== 32'h600) begin
          errors++;
          $display("FAIL trap_cancel off: got %h want 600", offset);
        end
      end
    end
  endtask

  task automatic test_trap_mode();
    logic [7:0] e [4] = '{8'h88, 8'h29, 8'h1C, 8'h00};
    issue(32'd4, 32'h0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      if (k == 2) begin
        trap = 1'b1;
        tick();
        trap = 1'b0;
      end else if (k > 0) begin
        tick();
      end
      checks++;
      if (obs !== e[k]) begin
        errors++;
        $display("FAIL trap_mode c%0d: got %b want %b", k, obs, e[k]);
      end
    end
  endtask

  task automatic test_trap_hold();
    trap = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (obs !== 8'h10) begin
        errors++;
        $display("FAIL trap_hold c%0d: got %b want %b", k, obs, 8'h10);
      end
    end
    trap = 1'b0;
    tick();
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL trap_release: got %b want %b", obs, 8'h00);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e [6] = '{8'h88, 8'h48, 8'h08, 8'h0C, 8'h00, 8'h00};
    int dn = 0;
    issue(32'd6, 32'h700, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      if (k == 1) begin
        proc_id    = 32'd2;
        base       = 32'h111;
        load       = 1'b1;
        enter_user = 1'b1;
        start      = 1'b1;
        tick();
        start      = 1'b0;
      end else if (k > 0) begin
        tick();
      end
      if (done) dn++;
      checks++;
      if (obs !== e[k]) begin
        errors++;
        $display("FAIL b2b c%0d: got %b want %b", k, obs, e[k]);
      end
    end
    checks++;
    if (dn != 1) begin
      errors++;
      $display("FAIL b2b done_count: got %0d want 1", dn);
    end
    checks++;
    if (sel !== 32'd6 || offset !== 32'h700) begin
      errors++;
      $display("FAIL b2b latch: got sel=%0d off=%h want 6 700",
               sel, offset);
    end
  endtask

  task automatic test_reset_mid();
    issue(32'd7, 32'h900, 1'b1, 1'b1);
    tick();
    checks++;
    if (obs !== 8'h48) begin
      errors++;
      $display("FAIL rst_mid pre: got %b want %b", obs, 8'h48);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 8'h00 || sel !== 32'h0 || offset !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid abort: got %b sel=%h off=%h want 0",
               obs, sel, offset);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid idle: got %b want %b", obs, 8'h00);
    end
    issue(32'd7, 32'h0, 1'b0, 1'b1);
    checks++;
    if (obs !== 8'h0A) begin
      errors++;
      $display("FAIL rst_mid err: got %b want %b", obs, 8'h0A);
    end
    tick();
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid end: got %b want %b", obs, 8'h00);
    end
  endtask

  initial begin
    test_reset();
    test_load_user();
    test_reuse();
    test_bad_id();
    test_trap_cancel();
    test_trap_mode();
    test_trap_hold();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/mmu_ctx_ctrl.md
# mmu_ctx_ctrl

Kernel-side context-switch sequencer that drives the MMU's programming port (`we_sel`/`sel`, `we_addr`/`offset`, `userMode`/`kernelMode`). It sits between the control unit's OS-support instructions and the MMU. It turns one request into the ordered write sequence the MMU requires: selector, then instruction-memory base, then mode change. It also tracks which of the 11 process slots hold a programmed base and forces kernel mode on traps.

## Interface
Parameters:
- `NUM_SLOTS`, 11: number of process slots; valid ids are 0..NUM_SLOTS-1.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request strobe; accepted only while `busy`=0.
- `proc_id`  in  32  target slot id.
- `base`  in  32  instruction-memory base for the slot.
- `load`  in  1  1 = write `base` to the slot; 0 = reuse the stored base.
- `enter_user`  in  1  1 = switch to user mode at the end of the sequence.
- `trap`  in  1  exception/syscall; forces kernel mode.
- `we_sel`  out  1  MMU selector write strobe.
- `sel`  out  32  MMU selector value.
- `we_addr`  out  1  MMU base write strobe.
- `offset`  out  32  MMU base value.
- `userMode`  out  1  MMU enter-user pulse.
- `kernelMode`  out  1  MMU enter-kernel pulse.
- `busy`  out  1  sequence in progress.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle rejection pulse.
- `mode`  out  1  mirror of the MMU execution mode: 0 = kernel, 1 = user.

## Operation
- All outputs are registered. Reset value of every output is 0, so `mode` resets to kernel. Reset also clears the slot-valid bitmap (`NUM_SLOTS` bits), clears the cancel flag, and returns the FSM to IDLE.
- When `start` is accepted, `proc_id`, `base`, `load` and `enter_user` are latched. Later changes to these inputs are ignored until the FSM is back in IDLE.
- FSM states: IDLE, SEL, BASE, MODE, DONE, ERR.
- IDLE with `start`:
  - If `proc_id` >= `NUM_SLOTS`, go to ERR.
  - Else if `load`=0 and the slot's valid bit is 0, go to ERR.
  - Otherwise go to SEL.
- SEL: `we_sel`=1 and `sel`=latched id for exactly one cycle. Next state is BASE if `load`=1, else MODE.
- BASE: `we_addr`=1 and `offset`=latched base for one cycle. The slot's valid bit is set. Next state is MODE. The base write must come after the selector write because the MMU indexes its base table with its registered selector.
- MODE: `userMode`=1 for one cycle only if `enter_user`=1 and the cancel flag is 0. In that case `mode` becomes 1. Next state is DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- ERR: `err`=1 for one cycle, then IDLE. No MMU strobes, no valid-bit change, `mode` unchanged.
- `busy`=1 in SEL, BASE, MODE, DONE and ERR.
- `start` while `busy`=1 is ignored; there is no queueing.
- Trap behaviour:
  - `trap` sampled high in any state gives `kernelMode`=1 in the following cycle and sets `mode` to 0.
  - If `trap` is sampled while the FSM is in SEL or BASE, the cancel flag is set. The remaining writes still complete, but MODE emits no `userMode`. The cancel flag is cleared on the next accepted `start`.
  - If `trap` and the MODE state coincide, `userMode` is still emitted and `kernelMode` follows one cycle later. Net mode is kernel.
  - `trap` held high for several cycles gives one `kernelMode` pulse per sampled cycle. This is harmless to the MMU.
- `sel` and `offset` hold their last written value between strobes. Only the strobes are pulses.
- Reset asserted mid-sequence aborts immediately: all strobes go to 0 and no `done` is produced. Whatever the MMU already captured stays captured.

## Timing
Cycle t is the edge where `start` is sampled.
- With `load`=1:
  - t+1: `we_sel`
  - t+2: `we_addr`
  - t+3: `userMode` (if requested)
  - t+4: `done`
  - The next `start` can be accepted at t+5.
- With `load`=0: `we_sel` at t+1, `userMode` at t+2, `done` at t+3.
- Rejected request: `err` at t+1, with `busy`=1 for that cycle only.
- `trap` sampled at edge u gives `kernelMode` and `mode`=0 visible after edge u+1.
- At most one MMU write strobe is high in any cycle.

## Test plan
- Reset, then `start` with id=3, base=0x400, load=1, enter_user=1 -> `we_sel`/`sel`=3 at t+1, `we_addr`/`offset`=0x400 at t+2, `userMode` at t+3, `done` at t+4, `mode`=1.
- `start` with id=3, load=0 after the previous case -> `we_sel` at t+1, `userMode` at t+2, `done` at t+3, no `we_addr`. Repeat the same request with id=5 (never loaded) -> `err` at t+1 and no strobes.
- `start` with id=11 -> `err` at t+1, no strobes, `mode` unchanged.
- Pulse `trap` at t+1 of a load=1, enter_user=1 request -> `kernelMode` at t+2, `we_addr` at t+2, no `userMode` at t+3, `done` at t+4, `mode`=0.
- `start` pulsed again at t+2 during a sequence -> ignored; exactly one `done` appears. Assert `rst_n`=0 at t+2 -> all outputs 0 at once, valid bitmap cleared, so a later load=0 request to the same id gives `err`.
